// File: rtl/inception_out_collector_pkg.sv
// Shared sizes and helpers for the Inception output collector.
// Sizes default to an 18-lane, 12-group, 5x5 feature map with 32-bit words.
package inception_out_collector_pkg;

    localparam int IMG_WIDTH  = 5;
    localparam int IMG_HEIGHT = 5;
    localparam int DATAWIDTH  = 32;
    localparam int CHANNEL    = 12;
    localparam int LANES      = 18;
    localparam int DEPTH      = 8;

    localparam int BEATS_PER_FRAME = IMG_WIDTH * IMG_HEIGHT * CHANNEL;
    localparam int WORDS_PER_FRAME = BEATS_PER_FRAME * LANES;
    localparam int BEAT_W          = LANES * DATAWIDTH;

    localparam int LANE_W  = $clog2(LANES);
    localparam int GRP_W   = $clog2(CHANNEL);
    localparam int CHAN_W  = $clog2(CHANNEL * LANES);
    localparam int X_W     = $clog2(IMG_WIDTH);
    localparam int Y_W     = $clog2(IMG_HEIGHT);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    // Lane k of a beat occupies bits [k*DATAWIDTH +: DATAWIDTH].
    function automatic logic [DATAWIDTH-1:0] lane_slice(input logic [BEAT_W-1:0] beat,
                                                        input logic [LANE_W-1:0] lane);
        return beat[int'(lane) * DATAWIDTH +: DATAWIDTH];
    endfunction

endpackage

// File: rtl/inception_out_collector_if.sv
// Beat input and tagged word output bundle of the collector.
interface inception_out_collector_if;
    import inception_out_collector_pkg::*;

    logic                 valid_in;
    logic [BEAT_W-1:0]    in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic [CHAN_W-1:0]    out_chan;
    logic [X_W-1:0]       out_x;
    logic [Y_W-1:0]       out_y;
    logic                 out_last;
    logic                 overflow;
    logic [LEVEL_W-1:0]   level;

    modport master (
        output valid_in, in_data, out_ready,
        input  out_valid, out_data, out_chan, out_x, out_y, out_last, overflow, level
    );

    modport slave (
        input  valid_in, in_data, out_ready,
        output out_valid, out_data, out_chan, out_x, out_y, out_last, overflow, level
    );

endinterface

// File: rtl/inception_out_collector_fifo.sv
// First-word-fall-through beat FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module inception_beat_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   level_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop_s  = pop && (level_r != '0);
        do_push_s = push && ((level_r != (PTR_W+1)'(DEPTH)) || do_pop_s);
    end

    // Pointers wrap naturally (DEPTH is a power of 2); level tracks push/pop directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            if (do_push_s && !do_pop_s)      level_r <= level_r + (PTR_W+1)'(1);
            else if (do_pop_s && !do_push_s) level_r <= level_r - (PTR_W+1)'(1);
            else                             level_r <= level_r;
        end
    end

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (level_r == (PTR_W+1)'(DEPTH));
    assign empty   = (level_r == '0);
    assign level   = level_r;

endmodule

// File: rtl/inception_out_collector.sv
// Collects Lanes-wide beats from an Inception block and serialises them into
// single words tagged with output channel, pixel position and end of frame.
module inception_out_collector
    import inception_out_collector_pkg::*;
(
    input logic                      clk,
    input logic                      rst,
    inception_out_collector_if.slave bus
);
    logic [BEAT_W-1:0]  head_s;
    logic               full_s;
    logic               empty_s;
    logic [LEVEL_W-1:0] level_s;
    logic               hs_s;
    logic               pop_s;
    logic               frame_end_s;

    logic [LANE_W-1:0]  lane_r;
    logic [GRP_W-1:0]   grp_r;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic               overflow_r;

    inception_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.valid_in),
        .pop     (pop_s),
        .wr_data (bus.in_data),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_s)
    );

    // Handshake decode; the head beat retires with its last lane.
    always_comb begin
        hs_s        = !empty_s && bus.out_ready;
        pop_s       = hs_s && (lane_r == LANE_W'(LANES - 1));
        frame_end_s = (grp_r == GRP_W'(CHANNEL - 1)) && (x_r == X_W'(IMG_WIDTH - 1))
                      && (y_r == Y_W'(IMG_HEIGHT - 1));
    end

    // Lane select within the head beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        lane_r <= '0;
        else if (pop_s) lane_r <= '0;
        else if (hs_s)  lane_r <= lane_r + LANE_W'(1);
        else            lane_r <= lane_r;
    end

    // Position of the head beat: channel group fastest, then column, then row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_r <= '0;
            x_r   <= '0;
            y_r   <= '0;
        end else if (pop_s) begin
            if (grp_r != GRP_W'(CHANNEL - 1)) begin
                grp_r <= grp_r + GRP_W'(1);
            end else begin
                grp_r <= '0;
                if (x_r != X_W'(IMG_WIDTH - 1)) begin
                    x_r <= x_r + X_W'(1);
                end else begin
                    x_r <= '0;
                    y_r <= (y_r == Y_W'(IMG_HEIGHT - 1)) ? '0 : y_r + Y_W'(1);
                end
            end
        end else begin
            grp_r <= grp_r;
        end
    end

    // Upstream cannot be stalled, so a dropped beat is remembered until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   overflow_r <= 1'b0;
        else if (bus.valid_in && full_s && !pop_s) overflow_r <= 1'b1;
        else                                       overflow_r <= overflow_r;
    end

    // Word outputs read zero whenever nothing is buffered.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_chan  = '0;
        bus.out_x     = '0;
        bus.out_y     = '0;
        bus.out_last  = 1'b0;
        if (!empty_s) begin
            bus.out_valid = 1'b1;
            bus.out_data  = lane_slice(head_s, lane_r);
            bus.out_chan  = CHAN_W'(grp_r) * CHAN_W'(LANES) + CHAN_W'(lane_r);
            bus.out_x     = x_r;
            bus.out_y     = y_r;
            bus.out_last  = frame_end_s && (lane_r == LANE_W'(LANES - 1));
        end else begin
            bus.out_valid = 1'b0;
        end
    end

    assign bus.overflow = overflow_r;
    assign bus.level    = level_s;

endmodule

// File: doc/inception_out_collector.md
Name: inception_out_collector

Overview:
- Consumer at the far end of an Inception block's parallel output stream: captures each Lanes-wide beat (qualified by valid_in) into a small FIFO.
- Drains the FIFO one word at a time onto a single ready/valid stream, tagging each word with its output channel index, pixel x/y and an end-of-frame marker.
- Sits between an InceptionN output (e.g. 18 lanes) and a memory writer or next-layer loader.
- Upstream has no backpressure, so loss is flagged rather than prevented.

Parameters:
- IMG_Width, 5, feature-map width in pixels
- IMG_Height, 5, feature-map height in pixels
- Datawidth, 32, bits per word
- Channel, 12, beats per pixel per lane (channel groups, interleaved fastest)
- Lanes, 18, parallel output lanes of the upstream block
- Depth, 8, FIFO depth in beats (power of 2, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- valid_in  in  1  upstream beat valid (no backpressure)
- in_data  in  Lanes*Datawidth  lane k at bits [k*Datawidth +: Datawidth]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  Datawidth  current word
- out_chan  out  clog2(Channel*Lanes)  output channel = grp*Lanes + lane
- out_x  out  clog2(IMG_Width)  pixel column
- out_y  out  clog2(IMG_Height)  pixel row
- out_last  out  1  last word of frame
- overflow  out  1  sticky: beat dropped
- level  out  clog2(Depth)+1  FIFO occupancy in beats

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, every pointer and counter 0, overflow=0.
  - out_valid=0, out_last=0; out_data/out_chan/out_x/out_y read 0.
  - Reset mid-frame discards all buffered beats; the next beat is channel 0, x=0, y=0.
- Push: valid_in=1 and (level<Depth or a pop occurs in the same cycle) -> beat written, level updates on the same edge.
- Full and no pop: beat dropped, overflow set to 1 and held until reset.
- Output is first-word-fall-through from the head beat.
  - A beat pushed into an empty FIFO at edge k shows out_valid=1 after edge k; latency is 1 cycle.
- lane counter (0..Lanes-1) selects the word from the head beat.
  - Handshake out_valid&&out_ready advances lane.
  - At lane=Lanes-1 the head beat pops and lane returns to 0.
- out_valid depends only on level!=0, never on out_ready.
- out_data/out_chan/out_x/out_y/out_last stay stable while out_valid&&!out_ready.
- Position counters advance on each pop: grp 0..Channel-1, then x 0..IMG_Width-1, then y 0..IMG_Height-1.
  - out_chan = grp*Lanes + lane.
- out_last=1 when grp=Channel-1, x=IMG_Width-1, y=IMG_Height-1 and lane=Lanes-1.
  - That pop wraps all counters to 0; the next frame follows with no gap.
- Simultaneous push and pop at level=Depth: both happen, level stays Depth, no overflow.
- Pointers wrap modulo Depth; level is computed from push/pop, not from pointer difference.
- Frame = IMG_Width*IMG_Height*Channel beats = that ×Lanes words (default 300 beats / 5400 words).
- No arithmetic on data; words pass through bit-exact.

Decomposition:
- Shared package:
  - BEATS_PER_FRAME = IMG_Width*IMG_Height*Channel
  - WORDS_PER_FRAME = BEATS_PER_FRAME*Lanes
  - counter widths via clog2
  - lane slice helper function
- One sub-module, inception_beat_fifo:
  - parameterised width Lanes*Datawidth and Depth
  - push / pop / level / full / empty
  - first-word-fall-through read
- Lane mux, position counters, handshake and overflow stay in the top.

Test Plan:
- Reset then one beat with lane k = 100+k, out_ready=1.
  - Required: out_valid one cycle after the push.
  - Words 100..117 on 18 consecutive cycles with out_chan 0..17, x=0, y=0.
  - level returns to 0 after the 18th word.
- Full frame (300 beats, lane k of beat i = i*32+k) with out_ready=1 and valid_in every 18th cycle.
  - Required: 5400 words in order; out_last only on word 5400 (chan 215, x=4, y=4).
  - overflow=0.
- out_ready=0 with 10 back-to-back beats, Depth=8.
  - Required: level=8; beats 9 and 10 dropped; overflow=1 and stays 1.
  - After releasing out_ready, exactly 8 beats (144 words) emerge in order.
- Stall mid-beat: out_ready low for 5 cycles at lane 7.
  - Required: out_data/out_chan frozen at lane 7 throughout the stall.
  - Resumes at lane 7 with no duplicate or skipped words.
- Level=8 with the pop of lane 17 coinciding with valid_in=1.
  - Required: level stays 8, overflow stays 0, the new beat is the last in order.
- Assert rst mid-frame (beat 150, level 3).
  - Required: outputs immediately 0 and level=0.
  - The next beat after release emerges with chan 0, x=0, y=0.
  - Two frames later out_last falls on the correct word.
